// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester arbiter for the single memory port.
// The instruction-fetch path (F_*) and the load/store data path (D_*) both use
// the MFA/MFC four-phase handshake. The winner's request is registered onto the
// memory port (M_*), and completion is returned to the winner only. Round-robin
// fairness decides ties, and a stuck-memory timeout aborts an access.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   i_f_mfa/i_f_addr  fetch request (always a word read) and address
//   o_f_mfc           fetch complete
//   i_d_mfa           data request; i_d_read_write 1=read, i_d_word_byte 1=word
//   i_d_addr/i_d_wdata data address and store data
//   o_d_mfc           data complete
//   o_rdata           read data of the last completed read (shared)
//   o_m_*             memory port request (mfa, read_write, word_byte, addr, wdata)
//   i_m_rdata/i_m_mfc memory read data and function complete
//   o_grant           one-hot owner: bit0 fetch, bit1 data, 00 when idle
//   o_timeout_err     sticky; set when an access is aborted by timeout
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_f_mfa,
  input  logic [31:0] i_f_addr,
  output logic        o_f_mfc,
  input  logic        i_d_mfa,
  input  logic        i_d_read_write,
  input  logic        i_d_word_byte,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  output logic        o_d_mfc,
  output logic [31:0] o_rdata,
  output logic        o_m_mfa,
  output logic        o_m_read_write,
  output logic        o_m_word_byte,
  output logic [31:0] o_m_addr,
  output logic [31:0] o_m_wdata,
  input  logic [31:0] i_m_rdata,
  input  logic        i_m_mfc,
  output logic [1:0]  o_grant,
  output logic        o_timeout_err
);

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  // Counter value on the last BUSY edge before the abort fires.
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : (TIMEOUT_CYCLES - 1));

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last_data;   // 1 = data path won the most recent grant
  logic [CNT_W-1:0] r_cnt;
  logic             r_f_mfc;
  logic             r_d_mfc;
  logic [31:0]      r_rdata;
  logic             r_m_mfa;
  logic             r_m_read_write;
  logic             r_m_word_byte;
  logic [31:0]      r_m_addr;
  logic [31:0]      r_m_wdata;
  logic [1:0]       r_grant;
  logic             r_timeout_err;

  logic w_idle_ok;
  logic w_pick_f;
  logic w_pick_d;
  logic w_owner_mfa;

  // Arbitration: a lone request wins; on a tie the side that did not win last.
  assign w_idle_ok   = ~i_m_mfc & ~r_f_mfc & ~r_d_mfc;
  assign w_pick_f    = i_f_mfa & (~i_d_mfa | r_last_data);
  assign w_pick_d    = i_d_mfa & (~i_f_mfa | ~r_last_data);
  assign w_owner_mfa = r_grant[0] ? i_f_mfa : i_d_mfa;

  // Arbiter FSM and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_last_data    <= 1'b1;
      r_cnt          <= '0;
      r_f_mfc        <= 1'b0;
      r_d_mfc        <= 1'b0;
      r_rdata        <= '0;
      r_m_mfa        <= 1'b0;
      r_m_read_write <= 1'b0;
      r_m_word_byte  <= 1'b0;
      r_m_addr       <= '0;
      r_m_wdata      <= '0;
      r_grant        <= 2'b00;
      r_timeout_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_idle_ok && (w_pick_f || w_pick_d)) begin
            r_m_mfa <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_BUSY;
            if (w_pick_f) begin
              r_m_addr       <= i_f_addr;
              r_m_read_write <= 1'b1;
              r_m_word_byte  <= 1'b1;
              r_m_wdata      <= '0;
              r_grant        <= 2'b01;
              r_last_data    <= 1'b0;
            end else begin
              r_m_addr       <= i_d_addr;
              r_m_read_write <= i_d_read_write;
              r_m_word_byte  <= i_d_word_byte;
              r_m_wdata      <= i_d_wdata;
              r_grant        <= 2'b10;
              r_last_data    <= 1'b1;
            end
          end
        end

        ST_BUSY: begin
          if (i_m_mfc) begin
            if (r_m_read_write) begin
              r_rdata <= i_m_rdata;
            end
            r_m_mfa <= 1'b0;
            r_f_mfc <= r_grant[0];
            r_d_mfc <= r_grant[1];
            r_state <= ST_DONE;
          end else if (TIMEOUT_EN && (r_cnt == TO_LAST)) begin
            // Abort is reported as a completion so the owner's handshake closes.
            r_m_mfa       <= 1'b0;
            r_timeout_err <= 1'b1;
            r_f_mfc       <= r_grant[0];
            r_d_mfc       <= r_grant[1];
            r_state       <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_DONE: begin
          // Hold MFC until the owner releases and the memory has let go of MFC.
          if (!w_owner_mfa && !i_m_mfc) begin
            r_f_mfc <= 1'b0;
            r_d_mfc <= 1'b0;
            r_grant <= 2'b00;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_f_mfc        = r_f_mfc;
  assign o_d_mfc        = r_d_mfc;
  assign o_rdata        = r_rdata;
  assign o_m_mfa        = r_m_mfa;
  assign o_m_read_write = r_m_read_write;
  assign o_m_word_byte  = r_m_word_byte;
  assign o_m_addr       = r_m_addr;
  assign o_m_wdata      = r_m_wdata;
  assign o_grant        = r_grant;
  assign o_timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes the expected memory
// request and completion of each transaction; a monitor pops and compares.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        f_mfa;
  logic [31:0] f_addr;
  logic        f_mfc;
  logic        d_mfa;
  logic        d_rw;
  logic        d_wb;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_mfc;
  logic [31:0] rdata;
  logic        m_mfa;
  logic        m_rw;
  logic        m_wb;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_mfc;
  logic [1:0]  grant;
  logic        timeout_err;

  mem_port_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_f_mfa(f_mfa), .i_f_addr(f_addr), .o_f_mfc(f_mfc),
    .i_d_mfa(d_mfa), .i_d_read_write(d_rw), .i_d_word_byte(d_wb),
    .i_d_addr(d_addr), .i_d_wdata(d_wdata), .o_d_mfc(d_mfc),
    .o_rdata(rdata),
    .o_m_mfa(m_mfa), .o_m_read_write(m_rw), .o_m_word_byte(m_wb),
    .o_m_addr(m_addr), .o_m_wdata(m_wdata),
    .i_m_rdata(m_rdata), .i_m_mfc(m_mfc),
    .o_grant(grant), .o_timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  g;
    logic [31:0] a;
    logic        rw;
    logic        wb;
    logic [31:0] wd;
  } gexp_t;

  typedef struct packed {
    logic [1:0]  who;   // {d_mfc, f_mfc} at the completion edge
    logic [31:0] rd;
  } cexp_t;

  gexp_t gq[$];
  cexp_t cq[$];
  int    pass_cnt = 0;
  int    total    = 0;

  // memory model controls
  logic  mem_silent = 1'b0;
  int    mem_delay  = 2;
  int    mem_hold   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'hE3A0_1005 : (a ^ 32'hA5A5_0000);
  endfunction

  // Memory model: answers after mem_delay cycles, holds MFC mem_hold cycles past MFA fall.
  initial begin
    int st;
    int cnt;
    st = 0; cnt = 0; m_mfc = 1'b0; m_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        st = 0; m_mfc = 1'b0;
      end else begin
        case (st)
          0: if (m_mfa && !mem_silent) begin cnt = 0; st = 1; end
          1: begin
            cnt++;
            if (cnt >= mem_delay) begin m_mfc = 1'b1; m_rdata = mem_val(m_addr); st = 2; end
          end
          2: if (!m_mfa) begin cnt = 0; st = 3; end
          default: begin
            if (cnt >= mem_hold) begin m_mfc = 1'b0; st = 0; end
            else cnt++;
          end
        endcase
      end
    end
  end

  // Monitor: memory request on M_MFA rise, completion on requester MFC rise.
  initial begin
    logic       prev_mfa;
    logic [1:0] prev_mfc;
    gexp_t      ge;
    cexp_t      ce;
    prev_mfa = 1'b0; prev_mfc = 2'b00;
    forever begin
      @(negedge clk);
      if (m_mfa && !prev_mfa) begin
        if (gq.size() == 0) begin
          total++;
          $display("FAIL grant_unexpected: got addr %h grant %b expected no request", m_addr, grant);
        end else begin
          ge = gq.pop_front();
          chk("grant",   32'(grant),   32'(ge.g));
          chk("m_addr",  m_addr,       ge.a);
          chk("m_rw",    32'(m_rw),    32'(ge.rw));
          chk("m_wb",    32'(m_wb),    32'(ge.wb));
          chk("m_wdata", m_wdata,      ge.wd);
        end
      end
      if ({d_mfc, f_mfc} != 2'b00 && prev_mfc == 2'b00) begin
        if (cq.size() == 0) begin
          total++;
          $display("FAIL mfc_unexpected: got mfc %b expected none", {d_mfc, f_mfc});
        end else begin
          ce = cq.pop_front();
          chk("mfc_who", 32'({d_mfc, f_mfc}), 32'(ce.who));
          chk("rdata",   rdata, ce.rd);
        end
      end
      prev_mfa = m_mfa;
      prev_mfc = {d_mfc, f_mfc};
    end
  end

  task automatic fetch_req(input logic [31:0] a);
    int i;
    f_addr = a; f_mfa = 1'b1;
    for (i = 0; i < 64 && !f_mfc; i++) @(negedge clk);
    if (!f_mfc) begin total++; $display("FAIL f_mfc_wait: got 0 expected 1 within 64 cycles"); end
    f_mfa = 1'b0;
    @(negedge clk);
    for (i = 0; i < 64 && f_mfc; i++) @(negedge clk);
    chk("f_mfc_release", 32'(f_mfc), 32'd0);
  endtask

  task automatic data_req(input logic rw, input logic wb, input logic [31:0] a,
                          input logic [31:0] wd, input int hold);
    int  i;
    logic ok;
    d_rw = rw; d_wb = wb; d_addr = a; d_wdata = wd; d_mfa = 1'b1;
    for (i = 0; i < 64 && !d_mfc; i++) @(negedge clk);
    if (!d_mfc) begin total++; $display("FAIL d_mfc_wait: got 0 expected 1 within 64 cycles"); end
    if (hold > 0) begin
      ok = 1'b1;
      for (i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!d_mfc) ok = 1'b0;
      end
      chk("d_mfc_hold", 32'(ok), 32'd1);
    end
    d_mfa = 1'b0;
    @(negedge clk);
    for (i = 0; i < 64 && d_mfc; i++) @(negedge clk);
    chk("d_mfc_release", 32'(d_mfc), 32'd0);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_mfc"},   32'({f_mfc, d_mfc, m_mfa, m_rw, m_wb}), 32'd0);
    chk({nm, "_rdata"}, rdata,   32'd0);
    chk({nm, "_addr"},  m_addr,  32'd0);
    chk({nm, "_wdata"}, m_wdata, 32'd0);
    chk({nm, "_grant"}, 32'({grant, timeout_err}), 32'd0);
  endtask

  initial begin
    int  n;
    logic bad;
    f_mfa = 0; f_addr = '0; d_mfa = 0; d_rw = 0; d_wb = 0; d_addr = '0; d_wdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Tie after reset: fetch first, then the data store.
    gq.push_back('{2'b01, 32'h40,  1'b1, 1'b1, 32'h0});
    gq.push_back('{2'b10, 32'h200, 1'b0, 1'b1, 32'hDEAD_BEEF});
    cq.push_back('{2'b01, 32'hA5A5_0040});
    cq.push_back('{2'b10, 32'hA5A5_0040});
    fork
      fetch_req(32'h40);
      data_req(1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, 0);
    join

    // Single fetch.
    gq.push_back('{2'b01, 32'h100, 1'b1, 1'b1, 32'h0});
    cq.push_back('{2'b01, 32'hE3A0_1005});
    fetch_req(32'h100);

    // Second tie with fetch last: data wins.
    gq.push_back('{2'b10, 32'h300, 1'b1, 1'b1, 32'h1234_5678});
    gq.push_back('{2'b01, 32'h104, 1'b1, 1'b1, 32'h0});
    cq.push_back('{2'b10, 32'hA5A5_0300});
    cq.push_back('{2'b01, 32'hA5A5_0104});
    fork
      fetch_req(32'h104);
      data_req(1'b1, 1'b1, 32'h300, 32'h1234_5678, 0);
    join

    // Byte read with D_MFA held after completion.
    gq.push_back('{2'b10, 32'h3, 1'b1, 1'b0, 32'h0});
    cq.push_back('{2'b10, 32'hA5A5_0003});
    data_req(1'b1, 1'b0, 32'h3, 32'h0, 3);

    // Timeout: memory never answers; RDATA keeps the last read.
    mem_silent = 1'b1;
    gq.push_back('{2'b01, 32'h500, 1'b1, 1'b1, 32'h0});
    cq.push_back('{2'b01, 32'hA5A5_0003});
    f_addr = 32'h500; f_mfa = 1'b1;
    for (int i = 0; i < 20 && !m_mfa; i++) @(negedge clk);
    n = 0;
    while (m_mfa && n < 20) begin n++; @(negedge clk); end
    chk("timeout_busy_edges", 32'(n), 32'd4);
    chk("timeout_err_set", 32'(timeout_err), 32'd1);
    chk("timeout_f_mfc", 32'(f_mfc), 32'd1);
    f_mfa = 1'b0;
    for (int i = 0; i < 20 && f_mfc; i++) @(negedge clk);
    mem_silent = 1'b0;
    gq.push_back('{2'b01, 32'h100, 1'b1, 1'b1, 32'h0});
    cq.push_back('{2'b01, 32'hE3A0_1005});
    fetch_req(32'h100);
    chk("timeout_err_sticky", 32'(timeout_err), 32'd1);

    // Late memory MFC with data pending: no new request while M_MFC is high.
    mem_hold = 3;
    gq.push_back('{2'b01, 32'h104, 1'b1, 1'b1, 32'h0});
    gq.push_back('{2'b10, 32'h200, 1'b0, 1'b1, 32'hCAFE_F00D});
    cq.push_back('{2'b01, 32'hA5A5_0104});
    cq.push_back('{2'b10, 32'hA5A5_0104});
    bad = 1'b0;
    fork
      fetch_req(32'h104);
      begin
        @(negedge clk);
        data_req(1'b0, 1'b1, 32'h200, 32'hCAFE_F00D, 0);
      end
      begin
        for (int i = 0; i < 40 && !f_mfc; i++) @(negedge clk);
        n = 0;
        for (int i = 0; i < 40 && m_mfc; i++) begin
          if (m_mfa) bad = 1'b1;
          if (!m_mfa) n++;
          @(negedge clk);
        end
      end
    join
    chk("late_mfc_no_grant", 32'(bad), 32'd0);
    chk("late_mfc_held", 32'(n >= 3), 32'd1);
    mem_hold = 0;

    // Reset mid-BUSY, then a tie goes to fetch.
    mem_silent = 1'b1;
    gq.push_back('{2'b01, 32'h700, 1'b1, 1'b1, 32'h0});
    f_addr = 32'h700; f_mfa = 1'b1;
    for (int i = 0; i < 20 && !m_mfa; i++) @(negedge clk);
    chk("busy_before_reset", 32'(m_mfa), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    f_mfa = 1'b0;
    mem_silent = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    gq.push_back('{2'b01, 32'h40,  1'b1, 1'b1, 32'h0});
    gq.push_back('{2'b10, 32'h100, 1'b1, 1'b1, 32'h0BAD_F00D});
    cq.push_back('{2'b01, 32'hA5A5_0040});
    cq.push_back('{2'b10, 32'hE3A0_1005});
    fork
      fetch_req(32'h40);
      data_req(1'b1, 1'b1, 32'h100, 32'h0BAD_F00D, 0);
    join

    repeat (4) @(negedge clk);
    chk("grant_queue_empty", 32'(gq.size()), 32'd0);
    chk("mfc_queue_empty",   32'(cq.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1);
  end

endmodule
